// File: rtl/corescore_jtag_rx_adapter.sv
// Host-to-core byte path from the JTAG-UART strobe interface into an AXI-stream.
// A small first-word-fall-through FIFO marks end-of-line bytes with tlast.
module corescore_jtag_rx_adapter #(
   parameter int         AW       = 4,
   parameter int         SLACK    = 2,
   parameter logic [7:0] EOL_CHAR = 8'h0A,
   parameter int         MAX_LINE = 64
) (
   input  logic          i_clk,
   input  logic          i_rst,
   input  logic [7:0]    i_rx_dat,
   input  logic          i_rx_ena,
   output logic          o_rx_dav,
   output logic [7:0]    o_tdata,
   output logic          o_tlast,
   output logic          o_tvalid,
   input  logic          i_tready,
   output logic          o_overflow,
   output logic [AW:0]   o_level
);

   localparam int              DEPTH     = 1 << AW;
   localparam int              LW        = $clog2(MAX_LINE) + 1;
   localparam logic [AW:0]     DEPTH_LVL = (AW+1)'(DEPTH);
   localparam logic [AW:0]     SLACK_LVL = (AW+1)'(SLACK);
   localparam logic [AW:0]     ONE_LVL   = (AW+1)'(1);
   localparam logic [AW-1:0]   ONE_PTR   = AW'(1);
   localparam logic [LW-1:0]   ONE_CNT   = LW'(1);
   localparam logic [LW-1:0]   LINE_END  = LW'(MAX_LINE - 1);

   logic [8:0]     mem [DEPTH];
   logic [AW-1:0]  wr_ptr;
   logic [AW-1:0]  rd_ptr;
   logic [AW:0]    level;
   logic [AW:0]    level_nxt;
   logic [LW-1:0]  line_cnt;
   logic           overflow;
   logic           rx_dav;
   logic           empty;
   logic           full;
   logic           push;
   logic           pop;
   logic           tlast_in;
   logic [8:0]     head;

   assign empty    = (level == '0);
   assign full     = (level == DEPTH_LVL);
   assign pop      = ~empty & i_tready;
   // A full FIFO still accepts a byte when the head leaves in the same cycle.
   assign push     = i_rx_ena & (~full | pop);
   assign tlast_in = (i_rx_dat == EOL_CHAR) | (line_cnt == LINE_END);

   always_comb begin
      level_nxt = level;
      if (push & ~pop)
         level_nxt = level + ONE_LVL;
      else if (pop & ~push)
         level_nxt = level - ONE_LVL;
   end

   always_ff @(posedge i_clk) begin
      if (push)
         mem[wr_ptr] <= {tlast_in, i_rx_dat};
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         level    <= '0;
         line_cnt <= '0;
         overflow <= 1'b0;
         rx_dav   <= 1'b0;
      end else begin
         level  <= level_nxt;
         rx_dav <= ((DEPTH_LVL - level_nxt) > SLACK_LVL);
         if (push) begin
            wr_ptr   <= wr_ptr + ONE_PTR;
            line_cnt <= tlast_in ? '0 : line_cnt + ONE_CNT;
         end
         if (pop)
            rd_ptr <= rd_ptr + ONE_PTR;
         if (i_rx_ena & ~push)
            overflow <= 1'b1;
      end
   end

   // Stale memory contents are masked so the stream reads zero while empty.
   assign head       = mem[rd_ptr];
   assign o_tvalid   = ~empty;
   assign o_tdata    = empty ? 8'h00 : head[7:0];
   assign o_tlast    = empty ? 1'b0 : head[8];
   assign o_rx_dav   = rx_dav;
   assign o_overflow = overflow;
   assign o_level    = level;

endmodule

// File: tb/tb_corescore_jtag_rx_adapter.sv
// Directed bench for corescore_jtag_rx_adapter: a reference model predicts
// occupancy/flags each cycle and a scoreboard queue checks every popped byte.
module tb_corescore_jtag_rx_adapter;

   logic       i_clk = 1'b0;
   logic       i_rst;
   logic [7:0] i_rx_dat;
   logic       i_rx_ena;
   logic       o_rx_dav;
   logic [7:0] o_tdata;
   logic       o_tlast;
   logic       o_tvalid;
   logic       i_tready;
   logic       o_overflow;
   logic [4:0] o_level;

   corescore_jtag_rx_adapter #(
      .AW(4), .SLACK(2), .EOL_CHAR(8'h0A), .MAX_LINE(64)
   ) dut (
      .i_clk      (i_clk),
      .i_rst      (i_rst),
      .i_rx_dat   (i_rx_dat),
      .i_rx_ena   (i_rx_ena),
      .o_rx_dav   (o_rx_dav),
      .o_tdata    (o_tdata),
      .o_tlast    (o_tlast),
      .o_tvalid   (o_tvalid),
      .i_tready   (i_tready),
      .o_overflow (o_overflow),
      .o_level    (o_level)
   );

   always #5 i_clk = ~i_clk;

   int         n_pass  = 0;
   int         n_total = 0;
   int         n_fail  = 0;
   int         m_level = 0;
   int         m_cnt   = 0;
   bit         m_ovf   = 1'b0;
   bit         m_dav   = 1'b0;
   logic [8:0] sb[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock: predict the edge from the driven inputs, then check after it.
   task automatic cycle();
      bit         pop;
      bit         acc;
      bit         tl;
      logic [8:0] exp;
      if (i_rst) begin
         m_level = 0;
         m_cnt   = 0;
         m_ovf   = 1'b0;
         m_dav   = 1'b0;
         sb.delete();
      end else begin
         pop = (m_level != 0) && i_tready;
         if (pop) begin
            if (sb.size() == 0) begin
               n_total++;
               n_fail++;
               $error("FAIL stream_extra: observed %0h expected none", {o_tlast, o_tdata});
            end else begin
               exp = sb.pop_front();
               chk("stream", 32'({o_tlast, o_tdata}), 32'(exp));
            end
         end
         acc = i_rx_ena && ((m_level < 16) || pop);
         if (i_rx_ena && !acc)
            m_ovf = 1'b1;
         if (acc) begin
            tl = (i_rx_dat == 8'h0A) || (m_cnt == 63);
            sb.push_back({tl, i_rx_dat});
            m_cnt = tl ? 0 : m_cnt + 1;
         end
         m_level = m_level + int'(acc) - int'(pop);
         m_dav   = ((16 - m_level) > 2);
      end
      @(posedge i_clk);
      #1;
      chk("level",    32'(o_level),    32'(m_level));
      chk("tvalid",   32'(o_tvalid),   32'(m_level != 0));
      chk("rx_dav",   32'(o_rx_dav),   32'(m_dav));
      chk("overflow", 32'(o_overflow), 32'(m_ovf));
   endtask

   task automatic push_byte(input logic [7:0] d);
      i_rx_ena = 1'b1;
      i_rx_dat = d;
      cycle();
      i_rx_ena = 1'b0;
   endtask

   task automatic drain(input int max_cycles);
      i_tready = 1'b1;
      for (int k = 0; k < max_cycles && m_level != 0; k++)
         cycle();
      if (m_level != 0) begin
         n_total++;
         n_fail++;
         $error("FAIL drain_timeout: observed level %0d expected 0", o_level);
      end
   endtask

   task automatic do_reset();
      i_rst    = 1'b1;
      i_rx_ena = 1'b0;
      cycle();
      i_rst = 1'b0;
   endtask

   initial begin
      i_rst    = 1'b1;
      i_rx_ena = 1'b0;
      i_rx_dat = 8'h00;
      i_tready = 1'b0;
      cycle();
      cycle();
      chk("tdata_rst", 32'(o_tdata), 32'h0);
      chk("tlast_rst", 32'(o_tlast), 32'h0);
      i_rst = 1'b0;
      cycle();
      cycle();
      cycle();

      // "Hi\n" with the consumer always ready
      i_tready = 1'b1;
      push_byte(8'h48);
      push_byte(8'h69);
      push_byte(8'h0A);
      drain(8);

      // fill to full, push-with-pop at full, then an overflowing byte
      i_tready = 1'b0;
      for (int i = 0; i < 16; i++)
         push_byte(8'(i));
      i_tready = 1'b1;
      push_byte(8'h55);
      i_tready = 1'b0;
      push_byte(8'hAA);
      cycle();
      drain(40);

      // forced tlast at 64 bytes, EOL at byte 70, second long line
      do_reset();
      for (int i = 0; i < 69; i++) begin
         i_tready = ($urandom_range(0, 3) != 0);
         push_byte(8'h41);
      end
      push_byte(8'h0A);
      for (int i = 0; i < 70; i++) begin
         i_tready = ($urandom_range(0, 3) != 0);
         push_byte(8'h41);
      end
      drain(200);

      // reset with 5 queued bytes and overflow set
      i_tready = 1'b0;
      for (int i = 0; i < 16; i++)
         push_byte(8'(8'h20 + i));
      push_byte(8'h7E);
      i_tready = 1'b1;
      repeat (11) cycle();
      i_tready = 1'b0;
      cycle();
      chk("queued_before_rst", 32'(o_level), 32'd5);
      do_reset();
      chk("tdata_after_rst", 32'(o_tdata), 32'h0);
      i_tready = 1'b1;
      push_byte(8'h31);
      for (int i = 0; i < 63; i++)
         push_byte(8'h41);
      push_byte(8'h42);
      drain(20);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
